ram_responder: RTL and testbench



---
 rtl/k_and_s_pkg.sv | 20 ++
 rtl/ram_word_array.sv | 39 +++
 rtl/ram_responder.sv | 174 +++++++++++++++++
 tb/tb_ram_responder.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/k_and_s_pkg.sv
// ============================================================================
// k_and_s_pkg : shared types and constants for the K&S core memory side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package k_and_s_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } ram_rsp_state_t;

  localparam int RAM_MAX_WAIT = 15;
  localparam int RAM_CNT_W    = 4;

endpackage

`default_nettype wire

// File: rtl/ram_word_array.sv
// ============================================================================
// ram_word_array : DEPTH x DATA_W storage, synchronous write, combinational read.
// Revision       : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_word_array #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_AW1   = ADDR_W + 1;
  localparam logic [ADDR_W:0] c_DEPTH = c_AW1'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              w_rd_in_range;

  // Writers only ever present in-range addresses; contents are never reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i[c_IDX_W-1:0]] <= wdata_i;
    end
  end

  assign w_rd_in_range = ({1'b0, raddr_i} < c_DEPTH);
  assign rdata_o       = w_rd_in_range ? mem_q[raddr_i[c_IDX_W-1:0]] : '0;

endmodule

`default_nettype wire

// File: rtl/ram_responder.sv
// ============================================================================
// ram_responder : wait-state RAM responder with valid/ready request/response.
// Optional store protection of words [0, PROT_WORDS) under macro RAM_WPROT_EN.
// Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_responder
  import k_and_s_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 5,
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 1,
  parameter int PROT_WORDS  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_write,
  output logic              rsp_err,
  output logic              busy
);

  generate
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > RAM_MAX_WAIT) begin : g_bad_wait
      $error("ram_responder: WAIT_CYCLES must be in 0..15");
    end
    if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
      $error("ram_responder: DEPTH must be in 1..2**ADDR_W");
    end
    if (PROT_WORDS < 0 || PROT_WORDS > DEPTH) begin : g_bad_prot
      $error("ram_responder: PROT_WORDS must be in 0..DEPTH");
    end
  endgenerate

  localparam int c_AW1 = ADDR_W + 1;
  localparam logic [ADDR_W:0]    c_DEPTH     = c_AW1'(DEPTH);
  localparam logic [RAM_CNT_W-1:0] c_WAIT_INIT =
    RAM_CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  ram_rsp_state_t       state_q, state_d;
  logic [RAM_CNT_W-1:0] cnt_q, cnt_d;
  logic                 write_q, write_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 err_q, err_d;
  logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_write_q, rsp_write_d;
  logic                 rsp_err_q, rsp_err_d;

  logic                 w_idle;
  logic                 w_accept;
  logic                 w_prot;
  logic                 w_err;
  logic                 w_we;
  logic [ADDR_W-1:0]    w_raddr;
  logic [DATA_W-1:0]    w_rdata;

  assign w_idle   = (state_q == IDLE);
  assign w_accept = w_idle && req_valid;

`ifdef RAM_WPROT_EN
  localparam logic [ADDR_W:0] c_PROT = c_AW1'(PROT_WORDS);
  assign w_prot = req_write && ({1'b0, req_addr} < c_PROT);
`else
  assign w_prot = 1'b0;
`endif

  assign w_err = ({1'b0, req_addr} >= c_DEPTH) || w_prot;
  // The store lands on the acceptance edge so a mid-operation reset cannot lose it.
  assign w_we  = w_accept && req_write && !w_err;
  // In IDLE the request address feeds the read port so a zero-wait read sees it.
  assign w_raddr = w_idle ? req_addr : addr_q;

  ram_word_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .we_i    (w_we),
    .waddr_i (req_addr),
    .wdata_i (req_wdata),
    .raddr_i (w_raddr),
    .rdata_o (w_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    err_d       = err_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_write_d = rsp_write_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          err_d   = w_err;
          if (WAIT_CYCLES == 0) begin
            state_d     = RESP;
            rsp_write_d = req_write;
            rsp_err_d   = w_err;
            rsp_rdata_d = (req_write || w_err) ? '0 : w_rdata;
          end else begin
            state_d = WAIT;
            cnt_d   = c_WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d     = RESP;
          rsp_write_d = write_q;
          rsp_err_d   = err_q;
          rsp_rdata_d = (write_q || err_q) ? '0 : w_rdata;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_rdata_d = '0;
          rsp_write_d = 1'b0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      err_q       <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_write_q <= rsp_write_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = w_idle;
  assign rsp_valid = (state_q == RESP);
  assign busy      = !w_idle;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_write = rsp_write_q;
  assign rsp_err   = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_responder.sv
// ============================================================================
// tb_ram_responder : self-checking bench for ram_responder (three configurations).
// Revision         : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_responder;

  localparam int N = 3;
  localparam int WAITS  [N] = '{1, 0, 3};
  localparam int DEPTHS [N] = '{24, 32, 32};
`ifdef RAM_WPROT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic        clk;
  logic        rst       [N];
  logic        req_valid [N];
  logic        req_ready [N];
  logic        req_write [N];
  logic [4:0]  req_addr  [N];
  logic [15:0] req_wdata [N];
  logic        rsp_valid [N];
  logic        rsp_ready [N];
  logic [15:0] rsp_rdata [N];
  logic        rsp_write [N];
  logic        rsp_err   [N];
  logic        busy      [N];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  generate
    for (genvar g = 0; g < N; g++) begin : g_dut
      ram_responder #(
        .DATA_W      (16),
        .ADDR_W      (5),
        .DEPTH       (DEPTHS[g]),
        .WAIT_CYCLES (WAITS[g]),
        .PROT_WORDS  (16)
      ) u_dut (
        .clk       (clk),
        .rst       (rst[g]),
        .req_valid (req_valid[g]),
        .req_ready (req_ready[g]),
        .req_write (req_write[g]),
        .req_addr  (req_addr[g]),
        .req_wdata (req_wdata[g]),
        .rsp_valid (rsp_valid[g]),
        .rsp_ready (rsp_ready[g]),
        .rsp_rdata (rsp_rdata[g]),
        .rsp_write (rsp_write[g]),
        .rsp_err   (rsp_err[g]),
        .busy      (busy[g])
      );
    end
  endgenerate

  // Reference memory: contents plus a flag saying whether a word was ever written.
  logic [15:0] mdl_mem [N][32];
  bit          mdl_kn  [N][32];

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (dut %0d, cycle %0d): got %0h expected %0h", name, k, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int k);
    n_checks++;
    n_err++;
    $display("FAIL %s (dut %0d, cycle %0d): timed out", name, k, cyc);
  endtask

  task automatic mdl(input int k, input bit w, input int a, input logic [15:0] d,
                     output bit err, output logic [15:0] rd, output bit known);
    err = (a >= DEPTHS[k]) || (PROT && w && a < 16);
    if (w && !err) begin
      mdl_mem[k][a] = d;
      mdl_kn[k][a]  = 1'b1;
    end
    rd    = (w || err) ? 16'h0 : mdl_mem[k][a];
    known = (w || err) ? 1'b1 : mdl_kn[k][a];
  endtask

  task automatic wait_ready(input int k, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready[k]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic accept(input int k, input bit w, input int a, input logic [15:0] d);
    req_valid[k] = 1'b1;
    req_write[k] = w;
    req_addr[k]  = a[4:0];
    req_wdata[k] = d;
    @(posedge clk);
    #1 req_valid[k] = 1'b0;
  endtask

  task automatic do_txn(input int k, input bit w, input int a, input logic [15:0] d,
                        input int hold, input bit e_err, input bit e_wr,
                        input logic [15:0] e_rd, input bit chk_rd);
    bit ok;
    int n;
    wait_ready(k, ok);
    if (!ok) begin
      fail_now("req_ready_wait", k);
      return;
    end
    accept(k, w, a, d);
    @(negedge clk);
    chk("busy_after_accept", k, busy[k], 1);
    chk("req_ready_after_accept", k, req_ready[k], 0);
    n = 1;
    while (!rsp_valid[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", k, n, WAITS[k] + 1);
    if (!rsp_valid[k]) return;
    chk("rsp_write", k, rsp_write[k], e_wr);
    chk("rsp_err", k, rsp_err[k], e_err);
    if (chk_rd) chk("rsp_rdata", k, rsp_rdata[k], e_rd);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", k, rsp_valid[k], 1);
      chk("hold_err", k, rsp_err[k], e_err);
      if (chk_rd) chk("hold_rdata", k, rsp_rdata[k], e_rd);
      chk("hold_req_ready", k, req_ready[k], 0);
    end
    rsp_ready[k] = 1'b1;
    @(posedge clk);
    #1 rsp_ready[k] = 1'b0;
    @(negedge clk);
    chk("post_valid", k, rsp_valid[k], 0);
    chk("post_rdata", k, rsp_rdata[k], 0);
    chk("post_write", k, rsp_write[k], 0);
    chk("post_err", k, rsp_err[k], 0);
    chk("post_busy", k, busy[k], 0);
    chk("post_req_ready", k, req_ready[k], 1);
  endtask

  task automatic txn_mdl(input int k, input bit w, input int a, input logic [15:0] d,
                         input int hold);
    bit e_err, kn;
    logic [15:0] e_rd;
    mdl(k, w, a, d, e_err, e_rd, kn);
    do_txn(k, w, a, d, hold, e_err, w, e_rd, kn);
  endtask

  // Accepts a request, then resets while the response is still pending.
  task automatic accept_then_reset(input int k, input bit w, input int a, input logic [15:0] d);
    bit ok, e_err, kn;
    logic [15:0] e_rd;
    wait_ready(k, ok);
    if (!ok) begin
      fail_now("reset_req_ready_wait", k);
      return;
    end
    mdl(k, w, a, d, e_err, e_rd, kn);
    accept(k, w, a, d);
    @(negedge clk);
    chk("reset_pre_busy", k, busy[k], 1);
    rst[k] = 1'b1;
    @(posedge clk);
    #1 rst[k] = 1'b0;
    @(negedge clk);
    chk("reset_valid", k, rsp_valid[k], 0);
    chk("reset_req_ready", k, req_ready[k], 1);
    chk("reset_busy", k, busy[k], 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("reset_no_rsp", k, rsp_valid[k], 0);
    end
  endtask

  typedef struct {
    bit          w;
    int          a;
    logic [15:0] d;
    int          hold;
    bit          e_err;
    bit          e_wr;
    logic [15:0] e_rd;
    bit          chk_rd;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit          e_err, kn;
    logic [15:0] e_rd;
    int          acc [$];
    int          rsp [$];

    tbl[0]  = '{1'b1,  3, 16'hBEEF, 0, PROT, 1'b1, 16'h0000, 1'b1};
    tbl[1]  = '{1'b0,  3, 16'h0000, 2, 1'b0, 1'b0, 16'hBEEF, !PROT};
    tbl[2]  = '{1'b1, 30, 16'h5555, 1, 1'b1, 1'b1, 16'h0000, 1'b1};
    tbl[3]  = '{1'b0, 30, 16'h0000, 0, 1'b1, 1'b0, 16'h0000, 1'b1};
    tbl[4]  = '{1'b1, 23, 16'h0F0F, 0, 1'b0, 1'b1, 16'h0000, 1'b1};
    tbl[5]  = '{1'b0, 23, 16'h0000, 1, 1'b0, 1'b0, 16'h0F0F, 1'b1};
    tbl[6]  = '{1'b0, 24, 16'h0000, 0, 1'b1, 1'b0, 16'h0000, 1'b1};
    tbl[7]  = '{1'b1, 16, 16'h1111, 0, 1'b0, 1'b1, 16'h0000, 1'b1};
    tbl[8]  = '{1'b0, 16, 16'h0000, 0, 1'b0, 1'b0, 16'h1111, 1'b1};
    tbl[9]  = '{1'b1,  2, 16'h00FF, 0, PROT, 1'b1, 16'h0000, 1'b1};
    tbl[10] = '{1'b0,  2, 16'h0000, 0, 1'b0, 1'b0, 16'h00FF, !PROT};
    tbl[11] = '{1'b1,  0, 16'hABCD, 1, PROT, 1'b1, 16'h0000, 1'b1};

    for (int k = 0; k < N; k++) begin
      rst[k] = 1'b1; req_valid[k] = 1'b0; req_write[k] = 1'b0;
      req_addr[k] = '0; req_wdata[k] = '0; rsp_ready[k] = 1'b0;
      for (int a = 0; a < 32; a++) begin
        mdl_mem[k][a] = '0;
        mdl_kn[k][a]  = 1'b0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) rst[k] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk("reset_req_ready", k, req_ready[k], 1);
      chk("reset_rsp_valid", k, rsp_valid[k], 0);
      chk("reset_rsp_rdata", k, rsp_rdata[k], 0);
      chk("reset_rsp_write", k, rsp_write[k], 0);
      chk("reset_rsp_err", k, rsp_err[k], 0);
      chk("reset_busy", k, busy[k], 0);
    end

    // Directed table on the DEPTH=24, one-wait-state responder.
    for (int i = 0; i < 12; i++) begin
      mdl(0, tbl[i].w, tbl[i].a, tbl[i].d, e_err, e_rd, kn);
      do_txn(0, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].hold,
             tbl[i].e_err, tbl[i].e_wr, tbl[i].e_rd, tbl[i].chk_rd);
    end

    // Zero wait states: long rsp_ready stall must hold data and block requests.
    txn_mdl(1, 1'b1, 17, 16'h7E57, 0);
    txn_mdl(1, 1'b0, 17, 16'h0000, 4);

    // Mid-operation reset: committed stores survive, pending responses vanish.
    txn_mdl(0, 1'b1, 5, 16'h1234, 0);
    accept_then_reset(0, 1'b1, 21, 16'h4321);
    accept_then_reset(0, 1'b0, 5, 16'h0000);
    txn_mdl(0, 1'b0, 21, 16'h0000, 0);
    txn_mdl(0, 1'b0, 5, 16'h0000, 0);

    // Three wait states, back-to-back reads with rsp_ready tied high.
    txn_mdl(2, 1'b1, 20, 16'hC0DE, 0);
    rsp_ready[2] = 1'b1;
    req_valid[2] = 1'b1;
    req_write[2] = 1'b0;
    req_addr[2]  = 5'd20;
    for (int i = 0; i < 16; i++) begin
      if (req_ready[2]) acc.push_back(cyc + 1);
      if (rsp_valid[2]) begin
        rsp.push_back(cyc + 1);
        chk("b2b_rdata", 2, rsp_rdata[2], 16'hC0DE);
      end
      @(negedge clk);
    end
    req_valid[2] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!busy[2]) break;
      @(negedge clk);
    end
    rsp_ready[2] = 1'b0;
    chk("b2b_drain", 2, busy[2], 0);
    if (acc.size() >= 3 && rsp.size() >= 2) begin
      chk("b2b_accept_gap0", 2, acc[1] - acc[0], 5);
      chk("b2b_accept_gap1", 2, acc[2] - acc[1], 5);
      chk("b2b_rsp_lat0", 2, rsp[0] - acc[0], 4);
      chk("b2b_rsp_lat1", 2, rsp[1] - acc[1], 4);
    end else begin
      fail_now("b2b_event_count", 2);
    end

    // Randomised traffic against the reference memory.
    for (int i = 0; i < 90; i++) begin
      int k;
      k = $urandom_range(0, N - 1);
      txn_mdl(k, 1'($urandom_range(0, 1)), $urandom_range(0, 31),
              16'($urandom), $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
